pl_ctrl: RTL

PL_CTRL -- requirements
Module: pl_ctrl

---
 rtl/cpu_types_pkg.sv | 30 +++
 rtl/pl_hazard_detect.sv | 16 +
 rtl/pl_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared pipeline-control types: FSM state, register index, and the enable/flush bundle.
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } pl_ctrl_state_t;

    // Bit order is pc, if/id, id/ex, ex/mem, mem/wb enables, then if/id, id/ex, ex/mem flushes.
    typedef struct packed {
        logic pc_wen;
        logic ifid_wen;
        logic idex_wen;
        logic exmem_wen;
        logic memwb_wen;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
    } pl_ctl_t;

    localparam pl_ctl_t CTL_FREEZE     = pl_ctl_t'(8'b00000_000);
    localparam pl_ctl_t CTL_NORMAL     = pl_ctl_t'(8'b11111_000);
    localparam pl_ctl_t CTL_REDIRECT   = pl_ctl_t'(8'b11111_110);
    localparam pl_ctl_t CTL_LOAD_USE   = pl_ctl_t'(8'b00111_010);
    localparam pl_ctl_t CTL_FETCH_MISS = pl_ctl_t'(8'b01111_100);

endpackage

// File: rtl/pl_hazard_detect.sv
// Load-use hazard detector: the ID/EX load writes a register the IF/ID instruction reads.
module pl_hazard_detect
    import cpu_types_pkg::*;
(
    input  logic     idex_memread,
    input  regbits_t idex_rt,
    input  regbits_t ifid_rs,
    input  regbits_t ifid_rt,
    output logic     load_use
);

    // Register zero is hardwired, so a load targeting it never creates a dependency.
    assign load_use = idex_memread && (idex_rt != '0) &&
                      ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

endmodule

// File: rtl/pl_ctrl.sv
// Pipeline controller: latch enables/flushes, data-miss wait, halt, optional perf counters.
// Optional counters are built when PL_CTRL_PERF_EN is defined; otherwise they read as zero.
module pl_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dmemREN,
    input  logic             dmemWEN,
    input  logic             idex_memread,
    input  regbits_t         idex_rt,
    input  regbits_t         ifid_rs,
    input  regbits_t         ifid_rt,
    input  logic             redirect,
    input  logic             memwb_halt,
    output logic             pc_wen,
    output logic             ifid_wen,
    output logic             idex_wen,
    output logic             exmem_wen,
    output logic             memwb_wen,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    pl_ctrl_state_t state, next_state;
    pl_ctl_t        ctl;
    logic           load_use;
    logic           mem_req;
    logic           data_miss;

    pl_hazard_detect u_hazard (
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .load_use     (load_use)
    );

    assign mem_req   = dmemREN | dmemWEN;
    assign data_miss = !dhit && (((state == RUN) && mem_req) || (state == DWAIT));

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= RUN;
        else       state <= next_state;
    end

    // NOTE: next_state gets a default first so no path through the case infers a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            RUN: begin
                if (memwb_halt)             next_state = HALTED;
                else if (mem_req && !dhit)  next_state = DWAIT;
            end
            DWAIT: begin
                if (memwb_halt)             next_state = HALTED;
                else if (dhit)              next_state = RUN;
            end
            HALTED:                         next_state = HALTED;
            default:                        next_state = RUN;
        endcase
    end

    always_comb begin
        ctl  = CTL_FREEZE;
        halt = 1'b0;
        // Held in reset: nothing may advance, regardless of the reset-state decode.
        if (nRST) begin
            if (state == HALTED) begin
                halt = 1'b1;
            end else if (!data_miss) begin
                if (redirect)      ctl = CTL_REDIRECT;
                else if (load_use) ctl = CTL_LOAD_USE;
                else if (!ihit)    ctl = CTL_FETCH_MISS;
                else               ctl = CTL_NORMAL;
                // Bubble behind the halt so nothing younger reaches MEM/WB; exmem_wen is 1 here.
                ctl.exmem_flush = (state == RUN) && memwb_halt;
            end
        end
    end

    assign pc_wen      = ctl.pc_wen;
    assign ifid_wen    = ctl.ifid_wen;
    assign idex_wen    = ctl.idex_wen;
    assign exmem_wen   = ctl.exmem_wen;
    assign memwb_wen   = ctl.memwb_wen;
    assign ifid_flush  = ctl.ifid_flush;
    assign idex_flush  = ctl.idex_flush;
    assign exmem_flush = ctl.exmem_flush;

`ifdef PL_CTRL_PERF_EN
    logic any_stall;
    logic any_flush;

    assign any_stall = nRST && (state != HALTED) &&
                       !(ctl.pc_wen && ctl.ifid_wen && ctl.idex_wen && ctl.exmem_wen && ctl.memwb_wen);
    assign any_flush = ctl.ifid_flush | ctl.idex_flush | ctl.exmem_flush;

    // Both counters saturate at all-ones rather than wrapping.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (any_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (any_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
